frv_intc: RTL and testbench

FRV_INTC -- requirements
Module: frv_intc

---
 rtl/frv_intc_if.sv | 20 ++
 rtl/frv_intc.sv | 141 ++++++++++++++
 tb/tb_frv_intc.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/frv_intc_if.sv
// MMIO register-window bus for the frv_intc interrupt controller.
// The master drives the access strobe; the slave returns combinational read data/error.
interface frv_intc_if;
  logic        mmio_en;
  logic        mmio_wen;
  logic [31:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;
  logic        mmio_error;

  modport master (
    output mmio_en, mmio_wen, mmio_addr, mmio_wdata,
    input  mmio_rdata, mmio_error
  );

  modport slave (
    input  mmio_en, mmio_wen, mmio_addr, mmio_wdata,
    output mmio_rdata, mmio_error
  );
endinterface

// File: rtl/frv_intc.sv
// Fixed-priority interrupt controller with edge/level sources, an MMIO register
// window (PENDING/ENABLE/MODE/CLAIM) and a single-level claim/complete handshake.
module frv_intc #(
  parameter int          NSRC           = 8,
  parameter logic [31:0] MMIO_BASE_ADDR = 32'h0000_2000,
  parameter logic [31:0] MMIO_BASE_MASK = 32'hFFFF_FFE0
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic [NSRC-1:0] src,
  frv_intc_if.slave       mmio,
  output logic            irq_req,
  output logic [4:0]      irq_id
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_d;
  logic [4:0]      cur_id_q, cur_id_d;
  logic [NSRC-1:0] src_q, src_d;
  logic [NSRC-1:0] src_rise_q, src_rise_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] en_q, en_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic            irq_req_q, irq_req_d;
  logic [4:0]      irq_id_q, irq_id_d;

  logic            hit, bad, acc, rd_acc, wr_acc;
  logic [2:0]      offset;
  logic [NSRC-1:0] masked, w1c, clr;
  logic [4:0]      win_id;
  logic            claim_valid, claim_take, complete;
  logic [31:0]     rd_val;
  logic            unused_wdata;

  assign unused_wdata = ^mmio.mmio_wdata;

  always_comb begin
    hit    = ((mmio.mmio_addr & MMIO_BASE_MASK) == MMIO_BASE_ADDR);
    offset = mmio.mmio_addr[4:2];
    bad    = (mmio.mmio_addr[1:0] != 2'b00) || offset[2];
    acc    = mmio.mmio_en && hit && !bad;
    rd_acc = acc && !mmio.mmio_wen;
    wr_acc = acc && mmio.mmio_wen;
  end

  assign mmio.mmio_error = mmio.mmio_en && hit && bad;

  // Lowest index wins: scan downwards so the last assignment is the smallest ID.
  always_comb begin
    masked = pend_q & en_q;
    win_id = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (masked[i]) win_id = 5'(i);
    end
  end

  always_comb begin
    claim_valid = (state_q == IDLE) && (|masked);
    claim_take  = rd_acc && (offset == 3'd3) && claim_valid;
    complete    = wr_acc && (offset == 3'd3) && (state_q == BUSY)
                  && (mmio.mmio_wdata[4:0] == cur_id_q);
  end

  // Edge pulses pass through src_rise_q so edge and level sources share the same latency.
  always_comb begin
    src_d      = src;
    src_rise_d = src & ~src_q;
    w1c        = (wr_acc && offset == 3'd0) ? mmio.mmio_wdata[NSRC-1:0] : '0;
    for (int i = 0; i < NSRC; i++) begin
      clr[i]    = w1c[i] || (claim_take && (win_id == 5'(i)));
      pend_d[i] = mode_q[i] ? (src_rise_q[i] || (pend_q[i] && !clr[i])) : src_q[i];
    end
    en_d   = (wr_acc && offset == 3'd1) ? mmio.mmio_wdata[NSRC-1:0] : en_q;
    mode_d = (wr_acc && offset == 3'd2) ? mmio.mmio_wdata[NSRC-1:0] : mode_q;
  end

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    case (state_q)
      IDLE: begin
        if (claim_take) begin
          state_d  = BUSY;
          cur_id_d = win_id;
        end
      end
      BUSY: begin
        if (complete) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The claim read itself drops the request so it is low in the following cycle.
  always_comb begin
    irq_req_d = (state_q == IDLE) && !claim_take && (|masked);
    irq_id_d  = irq_req_d ? win_id : irq_id_q;
  end

  always_comb begin
    rd_val = '0;
    case (offset)
      3'd0: rd_val[NSRC-1:0] = pend_q;
      3'd1: rd_val[NSRC-1:0] = en_q;
      3'd2: rd_val[NSRC-1:0] = mode_q;
      3'd3: if (claim_valid) rd_val = {1'b1, 26'b0, win_id};
      default: rd_val = '0;
    endcase
  end

  assign mmio.mmio_rdata = rd_acc ? rd_val : 32'h0;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q    <= IDLE;
      cur_id_q   <= '0;
      src_q      <= '0;
      src_rise_q <= '0;
      pend_q     <= '0;
      en_q       <= '0;
      mode_q     <= '0;
      irq_req_q  <= 1'b0;
      irq_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      cur_id_q   <= cur_id_d;
      src_q      <= src_d;
      src_rise_q <= src_rise_d;
      pend_q     <= pend_d;
      en_q       <= en_d;
      mode_q     <= mode_d;
      irq_req_q  <= irq_req_d;
      irq_id_q   <= irq_id_d;
    end
  end

  assign irq_req = irq_req_q;
  assign irq_id  = irq_id_q;

endmodule

// File: tb/tb_frv_intc.sv
// Directed scoreboard bench for frv_intc: edge/level sources, priority, masking,
// MMIO errors, claim/complete handshake and reset during a claim.
module tb_frv_intc;
  localparam int NSRC = 8;
  localparam logic [31:0] A_PEND  = 32'h0000_2000;
  localparam logic [31:0] A_EN    = 32'h0000_2004;
  localparam logic [31:0] A_MODE  = 32'h0000_2008;
  localparam logic [31:0] A_CLAIM = 32'h0000_200C;

  logic            g_clk;
  logic            g_reset;
  logic [NSRC-1:0] src;
  logic            irq_req;
  logic [4:0]      irq_id;

  frv_intc_if mmio ();

  frv_intc #(.NSRC(NSRC)) dut (
    .g_clk   (g_clk),
    .g_reset (g_reset),
    .src     (src),
    .mmio    (mmio),
    .irq_req (irq_req),
    .irq_id  (irq_id)
  );

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  string       tag_q[$];
  logic [31:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;

  task automatic push_expect(input string tag, input logic [31:0] val);
    tag_q.push_back(tag);
    exp_q.push_back(val);
  endtask

  task automatic check_output(input logic [31:0] obs);
    string       tag;
    logic [31:0] expv;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      tag  = tag_q.pop_front();
      expv = exp_q.pop_front();
      assert (obs === expv) else begin
        failures++;
        $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
        $error("[TB] check %s did not match", tag);
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge g_clk);
  endtask

  task automatic apply_stimulus(input logic [NSRC-1:0] v);
    src = v;
  endtask

  // Source high for one cycle; returns at the start of the following cycle.
  task automatic pulse(input logic [NSRC-1:0] v);
    apply_stimulus(v);
    tick(1);
    apply_stimulus('0);
  endtask

  task automatic mmio_wr(input logic [31:0] addr, input logic [31:0] data);
    mmio.mmio_en    = 1'b1;
    mmio.mmio_wen   = 1'b1;
    mmio.mmio_addr  = addr;
    mmio.mmio_wdata = data;
    tick(1);
    mmio.mmio_en    = 1'b0;
    mmio.mmio_wen   = 1'b0;
  endtask

  task automatic mmio_rd(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic exp_err);
    push_expect({tag, "_rdata"}, exp_data);
    push_expect({tag, "_err"}, {31'b0, exp_err});
    mmio.mmio_en   = 1'b1;
    mmio.mmio_wen  = 1'b0;
    mmio.mmio_addr = addr;
    #1;
    check_output(mmio.mmio_rdata);
    check_output({31'b0, mmio.mmio_error});
    tick(1);
    mmio.mmio_en = 1'b0;
  endtask

  task automatic irq_chk(input string tag, input logic exp_req, input logic [4:0] exp_id);
    push_expect({tag, "_req"}, {31'b0, exp_req});
    push_expect({tag, "_id"}, {27'b0, exp_id});
    check_output({31'b0, irq_req});
    check_output({27'b0, irq_id});
  endtask

  initial begin
    g_reset         = 1'b1;
    src             = '0;
    mmio.mmio_en    = 1'b0;
    mmio.mmio_wen   = 1'b0;
    mmio.mmio_addr  = '0;
    mmio.mmio_wdata = '0;
    tick(2);
    g_reset = 1'b0;

    // Reset state
    irq_chk("rst", 1'b0, 5'd0);
    mmio_rd("rst_pend", A_PEND, 32'h0, 1'b0);
    mmio_rd("rst_en", A_EN, 32'h0, 1'b0);
    mmio_rd("rst_mode", A_MODE, 32'h0, 1'b0);
    mmio_rd("rst_claim", A_CLAIM, 32'h0, 1'b0);

    // Edge, basic: pulse src[3]; PENDING at N+2, irq at N+3
    mmio_wr(A_MODE, 32'h08);
    mmio_wr(A_EN, 32'h08);
    pulse(8'h08);
    irq_chk("edge_n1", 1'b0, 5'd0);
    tick(1);
    irq_chk("edge_n2", 1'b0, 5'd0);
    mmio_rd("edge_pend", A_PEND, 32'h08, 1'b0);
    irq_chk("edge_n3", 1'b1, 5'd3);
    mmio_rd("edge_claim", A_CLAIM, 32'h8000_0003, 1'b0);
    irq_chk("edge_busy", 1'b0, 5'd3);
    mmio_rd("edge_pend_clr", A_PEND, 32'h0, 1'b0);
    mmio_rd("edge_nest", A_CLAIM, 32'h0, 1'b0);
    mmio_wr(A_CLAIM, 32'd3);
    irq_chk("edge_done0", 1'b0, 5'd3);
    tick(1);
    irq_chk("edge_done1", 1'b0, 5'd3);
    pulse(8'h08);
    tick(2);
    irq_chk("edge_idle_again", 1'b1, 5'd3);
    mmio_rd("edge_claim2", A_CLAIM, 32'h8000_0003, 1'b0);
    mmio_wr(A_CLAIM, 32'd3);

    // Priority: src[5] and src[2] together
    mmio_wr(A_MODE, 32'hFF);
    mmio_wr(A_EN, 32'hFF);
    pulse(8'h24);
    tick(2);
    irq_chk("prio_first", 1'b1, 5'd2);
    mmio_rd("prio_pend", A_PEND, 32'h24, 1'b0);
    mmio_rd("prio_claim2", A_CLAIM, 32'h8000_0002, 1'b0);
    irq_chk("prio_busy", 1'b0, 5'd2);
    mmio_wr(A_CLAIM, 32'd2);
    irq_chk("prio_c1", 1'b0, 5'd2);
    tick(1);
    irq_chk("prio_next", 1'b1, 5'd5);
    mmio_rd("prio_claim5", A_CLAIM, 32'h8000_0005, 1'b0);
    // Completion coincides with a new edge on the same source
    apply_stimulus(8'h20);
    tick(1);
    apply_stimulus('0);
    mmio_wr(A_CLAIM, 32'd5);
    tick(1);
    irq_chk("same_cycle_repend", 1'b1, 5'd5);
    mmio_rd("repend_claim", A_CLAIM, 32'h8000_0005, 1'b0);
    mmio_wr(A_CLAIM, 32'd5);

    // Level mode: W1C ignored, drop follows src
    mmio_wr(A_MODE, 32'h00);
    mmio_wr(A_EN, 32'h01);
    apply_stimulus(8'h01);
    tick(3);
    irq_chk("lvl_on", 1'b1, 5'd0);
    mmio_wr(A_PEND, 32'h01);
    mmio_rd("lvl_w1c", A_PEND, 32'h01, 1'b0);
    irq_chk("lvl_still", 1'b1, 5'd0);
    apply_stimulus('0);
    tick(1);
    irq_chk("lvl_drop1", 1'b1, 5'd0);
    tick(2);
    irq_chk("lvl_drop3", 1'b0, 5'd0);

    // Mask and errors
    mmio_wr(A_MODE, 32'h02);
    mmio_wr(A_EN, 32'h00);
    pulse(8'h02);
    tick(2);
    irq_chk("mask_off", 1'b0, 5'd0);
    mmio_rd("mask_pend", A_PEND, 32'h02, 1'b0);
    mmio_wr(A_EN, 32'h02);
    tick(1);
    irq_chk("mask_on", 1'b1, 5'd1);
    mmio_rd("err_off5", 32'h0000_2014, 32'h0, 1'b1);
    mmio_rd("err_misal", 32'h0000_2001, 32'h0, 1'b1);
    mmio_rd("miss", 32'h0000_3004, 32'h0, 1'b0);
    mmio_wr(32'h0000_2005, 32'hFF);
    mmio_rd("err_noeffect", A_EN, 32'h02, 1'b0);
    mmio_wr(A_EN, 32'hFFFF_FFFF);
    mmio_rd("en_width", A_EN, 32'hFF, 1'b0);
    mmio_wr(A_EN, 32'h02);
    mmio_rd("mask_claim", A_CLAIM, 32'h8000_0001, 1'b0);
    mmio_wr(A_CLAIM, 32'd7);
    pulse(8'h02);
    tick(2);
    irq_chk("wrong_id_busy", 1'b0, 5'd1);
    mmio_rd("wrong_id_claim", A_CLAIM, 32'h0, 1'b0);
    mmio_rd("wrong_id_pend", A_PEND, 32'h02, 1'b0);
    mmio_wr(A_CLAIM, 32'd1);
    tick(1);
    irq_chk("right_id_idle", 1'b1, 5'd1);

    // Reset mid-claim with PENDING=0x30
    mmio_wr(A_PEND, 32'h02);
    mmio_wr(A_EN, 32'h30);
    mmio_wr(A_MODE, 32'h32);
    pulse(8'h10);
    tick(2);
    irq_chk("pre_rst_irq", 1'b1, 5'd4);
    mmio_rd("pre_rst_claim", A_CLAIM, 32'h8000_0004, 1'b0);
    pulse(8'h30);
    tick(1);
    mmio_rd("pre_rst_pend", A_PEND, 32'h30, 1'b0);
    irq_chk("pre_rst_busy", 1'b0, 5'd4);
    g_reset         = 1'b1;
    apply_stimulus(8'hFF);
    mmio.mmio_en    = 1'b1;
    mmio.mmio_wen   = 1'b1;
    mmio.mmio_addr  = A_EN;
    mmio.mmio_wdata = 32'hFF;
    tick(1);
    g_reset       = 1'b0;
    mmio.mmio_en  = 1'b0;
    mmio.mmio_wen = 1'b0;
    apply_stimulus('0);
    irq_chk("post_rst", 1'b0, 5'd0);
    mmio_rd("post_rst_pend", A_PEND, 32'h0, 1'b0);
    mmio_rd("post_rst_en", A_EN, 32'h0, 1'b0);
    mmio_rd("post_rst_mode", A_MODE, 32'h0, 1'b0);
    mmio_rd("post_rst_claim", A_CLAIM, 32'h0, 1'b0);
    pulse(8'h10);
    tick(2);
    irq_chk("post_rst_noprog", 1'b0, 5'd0);
    mmio_rd("post_rst_pend2", A_PEND, 32'h0, 1'b0);
    mmio_wr(A_MODE, 32'h10);
    mmio_wr(A_EN, 32'h10);
    pulse(8'h10);
    tick(2);
    irq_chk("post_rst_prog", 1'b1, 5'd4);
    mmio_rd("post_rst_claim4", A_CLAIM, 32'h8000_0004, 1'b0);
    mmio_wr(A_CLAIM, 32'd4);
    tick(1);
    irq_chk("final_idle", 1'b0, 5'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
